game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
// - Round/level controller for the frogger top. Replaces the ad-hoc "reset = death | win | all-switches" glue.
// - Consumes collision flags and the slow clk_enable tick. Owns current_level and lives.
// - Generates round_reset for the frog and car instances, and freeze to stall car motion.
// - Adds death/win hold pauses and a game-over state.
// PARAMETERS
// - MAX_LEVEL        8   highest level; a win at MAX_LEVEL wraps to level 1
// - START_LIVES      3   lives loaded at game start (1..3)
// - DEATH_HOLD_TICKS 50  tick pulses spent in DYING before the next action (>=1)
// - WIN_HOLD_TICKS   50  tick pulses spent in WINNING before the next round (>=1)
// PORTS
// - clk              in   1  system clock
// - reset            in   1  asynchronous, active-high; full game restart
// - tick             in   1  one-clk pulse from ClockDivider (clk_enable)
// - death_collision  in   1  level; frog overlaps a car
// - win_collision    in   1  level; frog reached the goal row
// - user_restart     in   1  level; all four switches held (synchronous restart request)
// - current_level    out  4  1..MAX_LEVEL; drives car speeds and display
// - lives            out  2  remaining lives, 0..START_LIVES
// - round_reset      out  1  high while in START; resets frog and cars
// - freeze           out  1  high in DYING, WINNING and GAME_OVER; cars gate clk_enable with it
// - game_over        out  1  high in GAME_OVER
// - level_up         out  1  one-clk pulse on the WINNING->START transition
// BEHAVIOUR
// - All state registers are async-cleared by reset. Reset values:
//   - state=START, current_level=1, lives=START_LIVES, hold_cnt=0, level_up=0.
//   - Hence round_reset=1 and freeze=0 during reset.
// - round_reset, freeze and game_over are decoded from the state register. level_up is registered.
// - States and transitions, evaluated on each clk edge:
//   - START: -> PLAY unconditionally on the next clk. round_reset is high for exactly 1 clk.
//   - PLAY: death_collision -> DYING. Else win_collision -> WINNING.
//     - Death has priority when both are asserted in the same cycle.
//     - On entry to DYING: lives <= lives-1, hold_cnt <= DEATH_HOLD_TICKS.
//     - On entry to WINNING: hold_cnt <= WIN_HOLD_TICKS.
//   - DYING: decrement hold_cnt on each tick. When tick arrives with hold_cnt==1:
//     - lives==0 -> GAME_OVER.
//     - otherwise -> START. The level is unchanged.
//   - WINNING: decrement hold_cnt on each tick. When tick arrives with hold_cnt==1:
//     - go to START and pulse level_up;
//     - current_level <= (current_level==MAX_LEVEL) ? 1 : current_level+1.
//   - GAME_OVER: hold until user_restart.
// - Collision inputs are ignored outside PLAY; no re-trigger during the pause or during round_reset.
// - user_restart in any state, including mid-hold:
//   - next state START, current_level <= 1, lives <= START_LIVES, hold_cnt <= 0.
//   - It has priority over every other transition.
//   - While held, the block stays in START; PLAY is entered on the clk after release.
// - Latency:
//   - collision to freeze high: 1 clk.
//   - end of hold to round_reset: 1 clk. round_reset to PLAY: 1 clk.
// - Width rules:
//   - hold_cnt is $clog2(max(DEATH_HOLD_TICKS, WIN_HOLD_TICKS)+1) bits.
//   - lives never underflows; the decrement happens only on PLAY->DYING with lives>=1.
// - Async reset asserted mid-hold: immediate return to the reset values above; no level_up pulse.
// STRUCTURE
// - Shared package frogger_pkg:
//   - state enum: START=0, PLAY=1, DYING=2, WINNING=3, GAME_OVER=4 (3 bits);
//   - constants LEVEL_W=4, LIVES_W=2, MAX_LEVEL.
// - One sub-module: hold_timer.
//   - Loadable down-counter advanced by tick. Outputs expire when tick && cnt==1.
// - The top-level FSM and the level/lives registers live in game_sequencer.
// TESTING (tick forced every 4 clk; DEATH_HOLD_TICKS=WIN_HOLD_TICKS=3)
// - Reset release -> round_reset=1 for 1 clk, then PLAY; level=1, lives=3, freeze=0.
// - win_collision 1 clk in PLAY -> freeze next clk; after 3 ticks round_reset=1, level_up pulse, level=2.
// - Win at level 8 -> level wraps to 1 with a level_up pulse; lives unchanged.
// - Death and win in the same cycle -> DYING; lives 3->2; level unchanged; win ignored.
// - Three deaths -> lives 0, GAME_OVER, freeze=1; collisions ignored.
//   - Then user_restart -> START, level=1, lives=3.
// - user_restart mid-WINNING hold -> START next clk, level=1, no level_up.
//   - Async reset mid-DYING -> immediate START with lives=3.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger round/level control.
package frogger_pkg;

    localparam int LEVEL_W   = 4;
    localparam int LIVES_W   = 2;
    localparam int MAX_LEVEL = 8;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_WINNING   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_sequencer_hold_timer.sv
// Loadable down-counter advanced by the slow tick; flags the tick that ends a hold.
module hold_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);
    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over load; counting stops at zero so an idle timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (tick && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = tick && (cnt_q == W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Round/level controller: owns level and lives, sequences START/PLAY/hold pauses/game over.
module game_sequencer
    import frogger_pkg::*;
#(
    parameter int MAX_LEVEL        = frogger_pkg::MAX_LEVEL,
    parameter int START_LIVES      = 3,
    parameter int DEATH_HOLD_TICKS = 50,
    parameter int WIN_HOLD_TICKS   = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               death_collision,
    input  logic               win_collision,
    input  logic               user_restart,
    output logic [LEVEL_W-1:0] current_level,
    output logic [LIVES_W-1:0] lives,
    output logic               round_reset,
    output logic               freeze,
    output logic               game_over,
    output logic               level_up
);
    localparam int HOLD_W = $clog2(max2(DEATH_HOLD_TICKS, WIN_HOLD_TICKS) + 1);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               level_up_q, level_up_d;

    logic               tmr_clr, tmr_load, tmr_expire;
    logic [HOLD_W-1:0]  tmr_val;

    hold_timer #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (reset),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .expire   (tmr_expire)
    );

    // Next-state, level/lives update and hold-timer control; restart overrides everything.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        level_up_d = 1'b0;
        tmr_clr    = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        if (user_restart) begin
            state_d = ST_START;
            level_d = LEVEL_W'(1);
            lives_d = LIVES_W'(START_LIVES);
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_START: state_d = ST_PLAY;
                ST_PLAY: begin
                    if (death_collision) begin
                        state_d  = ST_DYING;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_W'(DEATH_HOLD_TICKS);
                        if (lives_q != '0) lives_d = lives_q - 1'b1;
                    end else if (win_collision) begin
                        state_d  = ST_WINNING;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_W'(WIN_HOLD_TICKS);
                    end
                end
                ST_DYING: begin
                    if (tmr_expire)
                        state_d = (lives_q == '0) ? ST_GAME_OVER : ST_START;
                end
                ST_WINNING: begin
                    if (tmr_expire) begin
                        state_d    = ST_START;
                        level_up_d = 1'b1;
                        level_d    = (level_q == LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(1)
                                                                      : level_q + 1'b1;
                    end
                end
                ST_GAME_OVER: state_d = ST_GAME_OVER;
                default:      state_d = ST_START;
            endcase
        end
    end

    // State, level, lives and level_up registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            level_q    <= LEVEL_W'(1);
            lives_q    <= LIVES_W'(START_LIVES);
            level_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            lives_q    <= lives_d;
            level_up_q <= level_up_d;
        end
    end

    assign current_level = level_q;
    assign lives         = lives_q;
    assign level_up      = level_up_q;
    assign round_reset   = (state_q == ST_START);
    assign freeze        = (state_q == ST_DYING) || (state_q == ST_WINNING) ||
                           (state_q == ST_GAME_OVER);
    assign game_over     = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with 3-tick holds and a tick every 4 clocks.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, death_collision, win_collision, user_restart;
    logic [3:0] current_level;
    logic [1:0] lives;
    logic       round_reset, freeze, game_over, level_up;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    game_sequencer #(
        .MAX_LEVEL        (8),
        .START_LIVES      (3),
        .DEATH_HOLD_TICKS (3),
        .WIN_HOLD_TICKS   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .death_collision (death_collision),
        .win_collision   (win_collision),
        .user_restart    (user_restart),
        .current_level   (current_level),
        .lives           (lives),
        .round_reset     (round_reset),
        .freeze          (freeze),
        .game_over       (game_over),
        .level_up        (level_up)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs and tick change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
    endtask

    // Run through a hold; returns ticks consumed and whether it ended in time.
    task automatic wait_hold(output int nt, output bit ok);
        int n = 0;
        nt = 0;
        while (!round_reset && !game_over && n < 40) begin
            if (tick) nt++;
            step();
            n++;
        end
        ok = (n < 40);
    endtask

    task automatic win_round(input int exp_next);
        int nt; bit ok;
        win_collision = 1'b1;
        step();
        win_collision = 1'b0;
        chk("win_freeze", freeze, 1);
        wait_hold(nt, ok);
        chk("win_hold_done", ok, 1);
        chk("win_ticks", nt, 3);
        chk("win_rr", round_reset, 1);
        chk("win_lvlup", level_up, 1);
        chk("win_level", current_level, exp_next);
        step();
        chk("win_play_rr", round_reset, 0);
        chk("win_lvlup_clr", level_up, 0);
        chk("win_play_frz", freeze, 0);
    endtask

    task automatic die_round(input int exp_lives, input int exp_level, input bit both);
        int nt; bit ok;
        death_collision = 1'b1;
        win_collision   = both;
        step();
        death_collision = 1'b0;
        win_collision   = 1'b0;
        chk("die_freeze", freeze, 1);
        chk("die_lives", lives, exp_lives);
        wait_hold(nt, ok);
        chk("die_hold_done", ok, 1);
        chk("die_ticks", nt, 3);
        chk("die_lvlup", level_up, 0);
        chk("die_level", current_level, exp_level);
        if (exp_lives == 0) chk("die_gameover", game_over, 1);
        else begin
            chk("die_rr", round_reset, 1);
            step();
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; death_collision = 1'b0;
        win_collision = 1'b0; user_restart = 1'b0;
        step(); step();
        chk("rst_rr", round_reset, 1);
        chk("rst_frz", freeze, 0);
        chk("rst_level", current_level, 1);
        chk("rst_lives", lives, 3);
        chk("rst_lvlup", level_up, 0);
        chk("rst_go", game_over, 0);
        reset = 1'b0;
        #1 chk("rel_rr", round_reset, 1);
        step();
        chk("play_rr", round_reset, 0);
        chk("play_frz", freeze, 0);

        // Wins up to level 8, then wrap to 1 with lives untouched.
        for (int l = 2; l <= 8; l++) win_round(l);
        win_round(1);
        chk("wrap_lives", lives, 3);

        // Death plus win together: death wins, third death ends the game.
        die_round(2, 1, 1'b1);
        die_round(1, 1, 1'b0);
        die_round(0, 1, 1'b0);
        chk("go_frz", freeze, 1);
        death_collision = 1'b1; win_collision = 1'b1;
        step(); step();
        death_collision = 1'b0; win_collision = 1'b0;
        chk("go_hold", game_over, 1);
        chk("go_lives", lives, 0);
        user_restart = 1'b1;
        step();
        chk("ur_rr", round_reset, 1);
        chk("ur_level", current_level, 1);
        chk("ur_lives", lives, 3);
        chk("ur_go", game_over, 0);
        step();
        chk("ur_held_rr", round_reset, 1);
        user_restart = 1'b0;
        step();
        chk("ur_rel_rr", round_reset, 0);
        chk("ur_rel_frz", freeze, 0);

        // Restart in the middle of a win hold.
        win_round(2);
        win_collision = 1'b1;
        step();
        win_collision = 1'b0;
        step(); step(); step();
        chk("mid_win_frz", freeze, 1);
        user_restart = 1'b1;
        step();
        user_restart = 1'b0;
        chk("mid_win_rr", round_reset, 1);
        chk("mid_win_level", current_level, 1);
        chk("mid_win_lvlup", level_up, 0);
        step();
        chk("mid_win_play", round_reset, 0);
        chk("mid_win_lvlup2", level_up, 0);

        // Async reset in the middle of a death hold, after reaching level 2.
        win_round(2);
        death_collision = 1'b1;
        step();
        death_collision = 1'b0;
        step();
        chk("ar_pre_lives", lives, 2);
        reset = 1'b1;
        #1;
        chk("ar_rr", round_reset, 1);
        chk("ar_frz", freeze, 0);
        chk("ar_lives", lives, 3);
        chk("ar_level", current_level, 1);
        step();
        reset = 1'b0;
        step();
        chk("ar_play", round_reset, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
